clk_div_ctrl: RTL and testbench

//   Run-time controller for a programmable clock divider. Generates a divided clock and a
//   per-period tick from clk_in. Accepts a new divide period over a valid/ready handshake
//   and commits it only at a period boundary, so clk_out never glitches.

---
 rtl/clk_div_pkg.sv | 5 +
 rtl/clk_div_core.sv | 28 ++
 rtl/clk_div_ctrl.sv | 66 ++++++
 tb/tb_clk_div_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding and defaults for the clock divider controller
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  localparam int MIN_PERIOD_DEF = 2;
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter, wrap detect and registered clk_out/tick
module clk_div_core #(
  parameter int wide = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            drain,
  input  logic [wide-1:0] period,
  output logic            wrap,
  output logic            tick,
  output logic            clk_out
);
  logic [wide-1:0] counter;
  assign wrap = run & (counter == period - wide'(1));
  // Masking the last drain cycle lets clk_out fall exactly as the divider goes idle
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      counter <= (!run || wrap) ? '0 : counter + wide'(1);
      tick    <= wrap;
      clk_out <= run & ~(drain & wrap) & (counter >= (period >> 1));
    end
  end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/drain FSM plus period handshake that commits only at period boundaries
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int              wide       = 24,
  parameter logic [wide-1:0] DEF_PERIOD = wide'(3_000_000),
  parameter int              MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            en,
  input  logic            cfg_valid,
  input  logic [wide-1:0] cfg_period,
  output logic            cfg_ready,
  output logic            cfg_err,
  output logic            clk_out,
  output logic            tick,
  output logic            running,
  output logic [wide-1:0] cur_period
);
  state_t          state, state_n;
  logic [wide-1:0] pending;
  logic            pending_valid, wrap, accept, commit, too_small;
  assign cfg_ready = ~pending_valid & ~rst;
  assign accept    = cfg_valid & cfg_ready;
  assign too_small = cfg_period < wide'(MIN_PERIOD);
  // A request accepted on a wrap edge has pending_valid=0 there, so it waits for the next wrap
  assign commit    = pending_valid & ((state == IDLE) | wrap);
  assign running   = state != IDLE;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (en ? RUN : IDLE)
            : en ? RUN
            : (state == DRAIN && wrap) ? IDLE : DRAIN;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state         <= IDLE;
      cur_period    <= DEF_PERIOD;
      pending       <= '0;
      pending_valid <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state   <= state_n;
      cfg_err <= accept & too_small;
      if (commit) begin
        cur_period    <= pending;
        pending_valid <= 1'b0;
      end
      if (accept && !too_small) begin
        pending       <= cfg_period;
        pending_valid <= 1'b1;
      end
    end
  end
  clk_div_core #(.wide(wide)) u_core (
    .clk    (clk_in),
    .rst    (rst),
    .run    (running),
    .drain  (state == DRAIN),
    .period (cur_period),
    .wrap   (wrap),
    .tick   (tick),
    .clk_out(clk_out)
  );
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: table-driven period checks plus hand sequences for reconfig, drain and reset
module tb_clk_div_ctrl;
  localparam logic [23:0] DEF = 24'd3_000_000;
  logic        clk_in = 1'b0, rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
  logic [23:0] cfg_period = '0;
  logic        cfg_ready, cfg_err, clk_out, tick, running;
  logic [23:0] cur_period;
  typedef struct packed {logic c; logic t;} exp_t;
  typedef struct {logic [23:0] period; logic err; int low; int high;} vec_t;
  exp_t        sb[$];
  vec_t        vecs[7];
  int          passed = 0, total = 0;
  logic [23:0] exp_cur;

  clk_div_ctrl dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_period(cfg_period),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .cur_period(cur_period)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0d want %0d", name, act, want);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_pattern(input int low, input int high, input int n);
    exp_t e;
    for (int p = 0; p < n; p++)
      for (int k = 0; k < low + high; k++) begin
        e.c = k >= low;
        e.t = k == low + high - 1;
        sb.push_back(e);
      end
  endtask

  task automatic push_period(input int p, input int cycles);
    exp_t e;
    for (int k = 0; k < cycles; k++) begin
      e.c = (k % p) >= p / 2;
      e.t = (k % p) == p - 1;
      sb.push_back(e);
    end
  endtask

  task automatic push_one(input logic c, input logic t);
    exp_t e;
    e.c = c;
    e.t = t;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: got empty scoreboard want entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_clk_out"}, clk_out, e.c);
      check({tag, "_tick"}, tick, e.t);
    end
  endtask

  task automatic wait_idle(input string tag);
    en = 1'b0;
    for (int i = 0; i < 200 && running; i++) step();
    check({tag, "_idle"}, running, 0);
    check({tag, "_idle_clk_out"}, clk_out, 0);
  endtask

  task automatic cfg_idle(input logic [23:0] p);
    cfg_valid = 1'b1;
    cfg_period = p;
    step();
    cfg_valid = 1'b0;
    step();
    check("cfg_idle_commit", cur_period, p);
    exp_cur = p;
  endtask

  initial begin
    vecs[0] = '{24'd4, 1'b0, 2, 2};
    vecs[1] = '{24'd5, 1'b0, 2, 3};
    vecs[2] = '{24'd2, 1'b0, 1, 1};
    vecs[3] = '{24'd7, 1'b0, 3, 4};
    vecs[4] = '{24'd1, 1'b1, 0, 0};
    vecs[5] = '{24'd0, 1'b1, 0, 0};
    vecs[6] = '{24'd3, 1'b0, 1, 2};
    step();
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_running", running, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_cur_period", cur_period, DEF);
    check("rst_cfg_ready", cfg_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cfg_ready", cfg_ready, 1);
    exp_cur = DEF;
    foreach (vecs[i]) begin
      cfg_valid = 1'b1;
      cfg_period = vecs[i].period;
      step();
      cfg_valid = 1'b0;
      check("vec_accept_cur", cur_period, exp_cur);
      if (vecs[i].err) begin
        check("vec_err_pulse", cfg_err, 1);
        check("vec_err_ready", cfg_ready, 1);
        step();
        check("vec_err_clear", cfg_err, 0);
        check("vec_err_cur", cur_period, exp_cur);
      end else begin
        check("vec_ready_low", cfg_ready, 0);
        check("vec_no_err", cfg_err, 0);
        step();
        check("vec_commit", cur_period, vecs[i].period);
        check("vec_ready_back", cfg_ready, 1);
        exp_cur = vecs[i].period;
        en = 1'b1;
        step();
        check("vec_running", running, 1);
        push_pattern(vecs[i].low, vecs[i].high, 3);
        for (int n = 0; n < 3 * (vecs[i].low + vecs[i].high); n++) begin
          step();
          pop_check("vec");
        end
        wait_idle("vec");
      end
    end
    cfg_idle(24'd4);
    en = 1'b1;
    step();
    push_period(4, 4);
    push_period(6, 12);
    push_period(4, 8);
    for (int i = 1; i <= 24; i++) begin
      if (i == 3) begin
        cfg_valid = 1'b1;
        cfg_period = 24'd6;
      end
      if (i == 10) begin
        cfg_valid = 1'b1;
        cfg_period = 24'd4;
      end
      step();
      pop_check("reconf");
      if (i == 3 || i == 10) begin
        cfg_valid = 1'b0;
        check("reconf_stall_ready", cfg_ready, 0);
        check("reconf_stall_cur", cur_period, i == 3 ? 6'd4 : 6'd6);
      end
      if (i == 4) begin
        check("reconf_commit6", cur_period, 6);
        check("reconf_ready6", cfg_ready, 1);
      end
      if (i == 16) begin
        check("reconf_commit4", cur_period, 4);
        check("reconf_ready4", cfg_ready, 1);
      end
    end
    wait_idle("reconf");
    en = 1'b1;
    step();
    push_one(0, 0);
    push_one(0, 0);
    push_one(1, 0);
    push_one(0, 1);
    push_one(0, 0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) en = 1'b0;
      step();
      pop_check("drain");
      if (k == 3) check("drain_running", running, 1);
      if (k == 4) check("drain_idle", running, 0);
    end
    en = 1'b1;
    step();
    push_period(4, 11);
    for (int k = 1; k <= 11; k++) begin
      if (k == 2) en = 1'b0;
      if (k == 3) en = 1'b1;
      if (k == 11) begin
        cfg_valid = 1'b1;
        cfg_period = 24'd5;
      end
      step();
      pop_check("resume");
      check("resume_running", running, 1);
    end
    cfg_valid = 1'b0;
    check("mid_high_clk_out", clk_out, 1);
    check("mid_pending_ready", cfg_ready, 0);
    rst = 1'b1;
    en = 1'b0;
    step();
    check("abort_clk_out", clk_out, 0);
    check("abort_tick", tick, 0);
    check("abort_running", running, 0);
    check("abort_cur", cur_period, DEF);
    check("abort_ready_in_rst", cfg_ready, 0);
    rst = 1'b0;
    #1;
    check("abort_pending_clear", cfg_ready, 1);
    step();
    step();
    check("abort_no_commit", cur_period, DEF);
    check("abort_still_idle", running, 0);
    check("abort_idle_clk_out", clk_out, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
